// File: rtl/be_rr_arbiter.sv
// be_rr_arbiter
// Round-robin arbiter merging N back-end masters onto the single L2 front-end
// port. A grant is registered and held for the whole transaction, with an
// IDLE state always visited between grants. The hold input blocks new grants
// (e.g. while an L2 force-invalidate is pending) but never aborts one in flight.

module be_rr_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 30,
   parameter int DATA_W    = 256
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_MASTERS-1:0]            m_valid,
   input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
   input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
   output logic [DATA_W-1:0]               m_rdata,
   output logic [N_MASTERS-1:0]            m_ready,
   output logic                            s_valid,
   output logic [ADDR_W-1:0]               s_addr,
   output logic [DATA_W-1:0]               s_wdata,
   output logic [DATA_W/8-1:0]             s_wstrb,
   input  logic [DATA_W-1:0]               s_rdata,
   input  logic                            s_ready,
   input  logic                            hold,
   output logic                            busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam int SEL_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   last_q, last_d;

   logic               sel_valid;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic [STRB_W-1:0]  sel_wstrb;

   logic               pick_found;
   logic [SEL_W-1:0]   pick_idx;
   int                 cand;

   // Route the currently selected master's request fields to a single set of wires
   always_comb begin
      sel_valid = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (sel_q == SEL_W'(i)) begin
            sel_valid = m_valid[i];
            sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = m_wdata[i*DATA_W +: DATA_W];
            sel_wstrb = m_wstrb[i*STRB_W +: STRB_W];
         end
      end
   end

   // Find the first requester after the last completed master, wrapping around
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = last_q;
      cand       = 0;
      for (int off = 1; off <= N_MASTERS; off++) begin
         cand = int'(last_q) + off;
         if (cand >= N_MASTERS) begin
            cand = cand - N_MASTERS;
         end
         if (!pick_found && m_valid[cand[SEL_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[SEL_W-1:0];
         end
      end
   end

   // Next-state and output decode; slave-side outputs are zero outside GRANT
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      busy    = 1'b0;
      s_valid = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      m_ready = '0;
      m_rdata = '0;
      case (state_q)
         IDLE: begin
            if (!hold && pick_found) begin
               sel_d   = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            busy    = 1'b1;
            s_valid = sel_valid;
            s_addr  = sel_addr;
            s_wdata = sel_wdata;
            s_wstrb = sel_wstrb;
            if (!sel_valid) begin
               state_d = IDLE;
            end else if (s_ready) begin
               m_ready = {{(N_MASTERS-1){1'b0}}, 1'b1} << sel_q;
               m_rdata = s_rdata;
               last_d  = sel_q;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; last resets to the top index so master 0 goes first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         last_q  <= SEL_W'(N_MASTERS - 1);
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_be_rr_arbiter.sv
// tb_be_rr_arbiter
// Directed bench for the two-master round-robin back-end arbiter: a vector
// table for the basic read and alternation sequences, then hand-written
// sequences for write routing, hold, and reset in the middle of a grant.

module tb_be_rr_arbiter;

   localparam int N  = 2;
   localparam int AW = 30;
   localparam int DW = 256;
   localparam int SW = DW / 8;

   logic              clk;
   logic              rst;
   logic [N-1:0]      m_valid;
   logic [N*AW-1:0]   m_addr;
   logic [N*DW-1:0]   m_wdata;
   logic [N*SW-1:0]   m_wstrb;
   logic [DW-1:0]     m_rdata;
   logic [N-1:0]      m_ready;
   logic              s_valid;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata;
   logic [SW-1:0]     s_wstrb;
   logic [DW-1:0]     s_rdata;
   logic              s_ready;
   logic              hold;
   logic              busy;

   logic [AW-1:0]     addr_m  [N];
   logic [DW-1:0]     wdata_m [N];
   logic [SW-1:0]     wstrb_m [N];
   logic [DW-1:0]     rdata_val;
   int                step_no;

   int                check_count;
   int                pass_count;

   typedef struct {
      logic [1:0] m_valid;
      logic       s_ready;
      logic       hold;
      logic       exp_s_valid;
      logic       exp_busy;
      logic [1:0] exp_m_ready;
      int         exp_grant;
   } vec_t;

   vec_t vecs [16];

   be_rr_arbiter #(
      .N_MASTERS (N),
      .ADDR_W    (AW),
      .DATA_W    (DW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .m_valid (m_valid),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_wstrb (m_wstrb),
      .m_rdata (m_rdata),
      .m_ready (m_ready),
      .s_valid (s_valid),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_wstrb (s_wstrb),
      .s_rdata (s_rdata),
      .s_ready (s_ready),
      .hold    (hold),
      .busy    (busy)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] mv, input logic sr, input logic hd);
      step_no++;
      rdata_val = {8{32'hC0DE_0000 + 32'(step_no)}};
      m_valid   = mv;
      s_ready   = sr;
      hold      = hd;
      s_rdata   = rdata_val;
   endtask

   // One cycle: drive after the edge, check at the falling edge, advance past the next edge
   task automatic stepCheck(input logic [1:0] mv, input logic sr, input logic hd,
                            input logic exp_sv, input logic exp_bz,
                            input logic [1:0] exp_mr, input int exp_grant,
                            input string tag);
      applyStimulus(mv, sr, hd);
      @(negedge clk);
      checkOutput({tag, " s_valid"}, DW'(s_valid), DW'(exp_sv));
      checkOutput({tag, " busy"},    DW'(busy),    DW'(exp_bz));
      checkOutput({tag, " m_ready"}, DW'(m_ready), DW'(exp_mr));
      if (exp_grant >= 0) begin
         checkOutput({tag, " s_addr"},  DW'(s_addr),  DW'(addr_m[exp_grant]));
         checkOutput({tag, " s_wdata"}, s_wdata,      wdata_m[exp_grant]);
         checkOutput({tag, " s_wstrb"}, DW'(s_wstrb), DW'(wstrb_m[exp_grant]));
      end
      if (exp_mr != 2'b00) begin
         checkOutput({tag, " m_rdata"}, m_rdata, rdata_val);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      step_no     = 0;

      // Master 0 issues reads at 0x100, master 1 writes full lines at 0x200
      addr_m[0]  = 30'h100;
      addr_m[1]  = 30'h200;
      wdata_m[0] = {32{8'h3C}};
      wdata_m[1] = {32{8'hA5}};
      wstrb_m[0] = '0;
      wstrb_m[1] = '1;
      m_addr     = {addr_m[1], addr_m[0]};
      m_wdata    = {wdata_m[1], wdata_m[0]};
      m_wstrb    = {wstrb_m[1], wstrb_m[0]};

      // Basic read, then continuous dual request with s_ready always high
      vecs[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1};
      vecs[1]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1};
      vecs[2]  = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00,  0};
      vecs[3]  = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00,  0};
      vecs[4]  = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00,  0};
      vecs[5]  = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01,  0};
      vecs[6]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1};
      vecs[7]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, -1};
      vecs[8]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10,  1};
      vecs[9]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, -1};
      vecs[10] = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01,  0};
      vecs[11] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, -1};
      vecs[12] = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10,  1};
      vecs[13] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, -1};
      vecs[14] = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01,  0};
      vecs[15] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1};

      // Reset with requests present: everything must stay quiet
      rst = 1'b1;
      applyStimulus(2'b11, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset s_valid", DW'(s_valid), '0);
      checkOutput("reset busy",    DW'(busy),    '0);
      checkOutput("reset m_ready", DW'(m_ready), '0);
      checkOutput("reset s_addr",  DW'(s_addr),  '0);
      checkOutput("reset s_wdata", s_wdata,      '0);
      checkOutput("reset s_wstrb", DW'(s_wstrb), '0);
      checkOutput("reset m_rdata", m_rdata,      '0);
      @(posedge clk);
      #1;
      applyStimulus(2'b00, 1'b0, 1'b0);
      rst = 1'b0;

      // Table-driven part
      for (int i = 0; i < 16; i++) begin
         stepCheck(vecs[i].m_valid, vecs[i].s_ready, vecs[i].hold,
                   vecs[i].exp_s_valid, vecs[i].exp_busy, vecs[i].exp_m_ready,
                   vecs[i].exp_grant, $sformatf("vec%0d", i));
      end

      // Master 1 write held for several cycles; master 0 never sees ready
      stepCheck(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, "wr idle");
      for (int i = 0; i < 3; i++) begin
         stepCheck(2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1, $sformatf("wr grant%0d", i));
      end
      stepCheck(2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10,  1, "wr done");
      stepCheck(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, "wr after");

      // hold blocks new grants but not an in-flight one
      for (int i = 0; i < 10; i++) begin
         stepCheck(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, -1, $sformatf("hold%0d", i));
      end
      stepCheck(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, "hold release");
      stepCheck(2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00,  1, "hold grant a");
      stepCheck(2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00,  1, "hold grant b");
      stepCheck(2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10,  1, "hold complete");
      stepCheck(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, -1, "hold reblocked");
      stepCheck(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, "hold end");

      // Leave last pointing at master 0 so a reset of last is observable
      stepCheck(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, "m0 idle");
      stepCheck(2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01,  0, "m0 done");

      // Reset in the middle of a master 1 grant
      stepCheck(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, "rst idle");
      applyStimulus(2'b10, 1'b1, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rst mid s_valid", DW'(s_valid), '0);
      checkOutput("rst mid busy",    DW'(busy),    '0);
      checkOutput("rst mid m_ready", DW'(m_ready), '0);
      @(posedge clk);
      #1;
      applyStimulus(2'b11, 1'b0, 1'b0);
      rst = 1'b0;
      stepCheck(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, "post rst idle");
      stepCheck(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01,  0, "post rst m0 wins");
      stepCheck(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, "post rst end");

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
